// File: rtl/arp_responder.sv
// ARP reply generator: filters decoded ARP requests for local_ip and streams the 28-byte reply payload once the TX arbiter grants.
// Optional statistics counters (rpl_cnt, drop_cnt) are enabled by defining ARP_STATS_EN.
module arp_responder #(
  parameter logic [7:0]  REQ_TIMEOUT = 8'd255,
  parameter int unsigned STATS_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_done,
  input  logic        dec_err,
  input  logic [47:0] dec_sha,
  input  logic [31:0] dec_spa,
  input  logic [31:0] dec_tpa,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic        drop
`ifdef ARP_STATS_EN
  ,
  output logic [STATS_W-1:0] rpl_cnt,
  output logic [STATS_W-1:0] drop_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;

  // HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4, OPER=2; byte 0 sits in bits [7:0]
  localparam logic [63:0] ARP_HDR  = 64'h0200_0406_0008_0100;
  localparam logic [4:0]  LAST_IDX = 5'd27;

  state_t      state_q, state_d;
  logic [47:0] tha_q, tha_d;
  logic [31:0] tpa_q, tpa_d;
  logic [4:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        tx_req_q, tx_req_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  logic [223:0] payload;
  logic [4:0]   nxt_idx;

  assign payload = {tpa_q, tha_q, local_ip, local_mac, ARP_HDR};
  assign nxt_idx = byte_cnt_q + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tha_q      <= '0;
      tpa_q      <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      tx_req_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tha_q      <= tha_d;
      tpa_q      <= tpa_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      tx_req_q   <= tx_req_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tha_d      = tha_q;
    tpa_d      = tpa_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    tx_req_d   = tx_req_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    tx_data_d  = tx_data_q;
    drop_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dec_done) begin
          if (!dec_err && dec_tpa == local_ip) begin
            state_d  = S_REQ;
            tha_d    = dec_sha;
            tpa_d    = dec_spa;
            to_cnt_d = '0;
            tx_req_d = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        drop_d = dec_done;
        // Grant is checked first so it wins over a coincident timeout
        if (tx_grant) begin
          state_d    = S_SEND;
          byte_cnt_d = '0;
          tx_valid_d = 1'b1;
          tx_last_d  = 1'b0;
          tx_data_d  = payload[7:0];
        end else if (REQ_TIMEOUT != 8'd0 && to_cnt_q + 8'd1 == REQ_TIMEOUT) begin
          state_d  = S_IDLE;
          tx_req_d = 1'b0;
          drop_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      S_SEND: begin
        drop_d = dec_done;
        if (tx_valid_q && tx_ready) begin
          if (byte_cnt_q == LAST_IDX) begin
            state_d    = S_IDLE;
            tx_req_d   = 1'b0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
          end else begin
            byte_cnt_d = nxt_idx;
            tx_data_d  = payload[{nxt_idx, 3'b000} +: 8];
            tx_last_d  = (nxt_idx == LAST_IDX);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign tx_req   = tx_req_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign drop     = drop_q;

`ifdef ARP_STATS_EN
  logic               rpl_inc;
  logic [STATS_W-1:0] rpl_cnt_q, drop_cnt_q;

  assign rpl_inc = (state_q == S_SEND) && tx_valid_q && tx_ready && (byte_cnt_q == LAST_IDX);

  // Saturating counters: they stick at all-ones rather than wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpl_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (rpl_inc && rpl_cnt_q != '1)
        rpl_cnt_q <= rpl_cnt_q + 1'b1;
      if (drop_d && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign rpl_cnt  = rpl_cnt_q;
  assign drop_cnt = drop_cnt_q;
`else
  // No statistics logic in this build.
`endif

endmodule
